// File: rtl/packet_flit_transmitter_if.sv
// Load, link and acknowledgement signals of the packet flit transmitter.
// The slave modport is the transmitter; the master modport is the node/link side.
interface packet_flit_transmitter_if #(
    parameter int FLIT_WIDTH      = 64,
    parameter int PACKET_ID_WIDTH = 8
);
    // Handshake: a flit moves on a cycle where valid && ready are both high at
    // the rising clock edge; the sender holds data stable while valid is high and
    // ready is low, and valid is never withdrawn until that transfer happens.
    logic                       in_valid;
    logic                       in_ready;
    logic [FLIT_WIDTH-1:0]      in_flit;
    logic                       in_last;
    logic [PACKET_ID_WIDTH-1:0] in_packet_id;
    logic                       out_valid;
    logic                       out_ready;
    logic [FLIT_WIDTH-1:0]      out_flit;
    logic                       out_last;
    logic                       ack_valid;
    logic [PACKET_ID_WIDTH-1:0] ack_packet_id;

    modport slave (
        input  in_valid, in_flit, in_last, in_packet_id,
        output in_ready,
        output out_valid, out_flit, out_last,
        input  out_ready,
        input  ack_valid, ack_packet_id
    );

    modport master (
        output in_valid, in_flit, in_last, in_packet_id,
        input  in_ready,
        input  out_valid, out_flit, out_last,
        output out_ready,
        output ack_valid, ack_packet_id
    );
endinterface

// File: rtl/packet_flit_transmitter.sv
// Buffers one outbound packet, streams it onto the link and holds it until a
// matching ack or expiry. Define PACKET_TX_RETRY_EN to retransmit on expiry.
module packet_flit_transmitter #(
    parameter int MAX_NUM_OF_FLIT = 8,
    parameter int EXPIRE_TIME     = 100,
    parameter int FLIT_WIDTH      = 64,
    parameter int PACKET_ID_WIDTH = 8,
    parameter int MAX_RETRY       = 3
) (
    input  logic                        clk,
    input  logic                        rst,
    packet_flit_transmitter_if.slave    bus,
    output logic                        busy,
    output logic                        tx_done,
    output logic                        tx_fail,
    output logic [2:0]                  dbg_state_o
);
    localparam int TIW = (MAX_NUM_OF_FLIT > 1) ? $clog2(MAX_NUM_OF_FLIT) : 1;
    localparam int TW  = (EXPIRE_TIME > 1) ? $clog2(EXPIRE_TIME) : 1;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_LOAD     = 3'd1,
        S_SEND     = 3'd2,
        S_WAIT_ACK = 3'd3,
        S_DONE     = 3'd4,
        S_FAIL     = 3'd5
    } state_e;

    state_e                     state_q, state_d;
    logic [TIW-1:0]             tail_q, tail_d;
    logic [TIW-1:0]             rd_q, rd_d;
    logic [TW-1:0]              timer_q, timer_d;
    logic [PACKET_ID_WIDTH-1:0] pid_q, pid_d;
    logic                       in_ready_q, in_ready_d;
    logic [FLIT_WIDTH-1:0]      buf_q [MAX_NUM_OF_FLIT];

    logic                       wr_en;
    logic [TIW-1:0]             wr_addr;
    logic                       accept;
    logic                       xfer;
    logic                       ack_hit;
    logic                       timeout;

`ifdef PACKET_TX_RETRY_EN
    localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    logic [RW-1:0] retry_q, retry_d;
`endif

    always_comb begin
        state_d    = state_q;
        tail_d     = tail_q;
        rd_d       = rd_q;
        timer_d    = timer_q;
        pid_d      = pid_q;
        wr_en      = 1'b0;
        wr_addr    = '0;
        accept     = bus.in_valid && in_ready_q;
        xfer       = (state_q == S_SEND) && bus.out_ready;
        ack_hit    = bus.ack_valid && (bus.ack_packet_id == pid_q);
        timeout    = (timer_q == TW'(EXPIRE_TIME - 1));
`ifdef PACKET_TX_RETRY_EN
        retry_d    = retry_q;
`endif
        case (state_q)
            S_IDLE: begin
                rd_d    = '0;
                timer_d = '0;
`ifdef PACKET_TX_RETRY_EN
                retry_d = '0;
`endif
                if (accept) begin
                    wr_en   = 1'b1;
                    wr_addr = '0;
                    pid_d   = bus.in_packet_id;
                    tail_d  = '0;
                    state_d = (bus.in_last || (MAX_NUM_OF_FLIT == 1)) ? S_SEND : S_LOAD;
                end
            end
            S_LOAD: begin
                if (accept) begin
                    wr_en   = 1'b1;
                    wr_addr = tail_q + TIW'(1);
                    tail_d  = tail_q + TIW'(1);
                    // A full buffer closes the packet even without in_last.
                    if (bus.in_last || (tail_q == TIW'(MAX_NUM_OF_FLIT - 2))) begin
                        state_d = S_SEND;
                    end
                end
            end
            S_SEND: begin
                if (xfer) begin
                    if (rd_q == tail_q) begin
                        state_d = S_WAIT_ACK;
                        timer_d = '0;
                    end else begin
                        rd_d = rd_q + TIW'(1);
                    end
                end
            end
            S_WAIT_ACK: begin
                // A matching ack takes priority over expiry in the same cycle.
                if (ack_hit) begin
                    state_d = S_DONE;
                end else if (timeout) begin
`ifdef PACKET_TX_RETRY_EN
                    if (retry_q < RW'(MAX_RETRY)) begin
                        retry_d = retry_q + RW'(1);
                        rd_d    = '0;
                        state_d = S_SEND;
                    end else begin
                        state_d = S_FAIL;
                    end
`else
                    state_d = S_FAIL;
`endif
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            S_DONE:  state_d = S_IDLE;
            S_FAIL:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        in_ready_d = (state_d == S_IDLE) || (state_d == S_LOAD);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            tail_q     <= '0;
            rd_q       <= '0;
            timer_q    <= '0;
            pid_q      <= '0;
            in_ready_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            tail_q     <= tail_d;
            rd_q       <= rd_d;
            timer_q    <= timer_d;
            pid_q      <= pid_d;
            in_ready_q <= in_ready_d;
        end
    end

`ifdef PACKET_TX_RETRY_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            retry_q <= '0;
        end else begin
            retry_q <= retry_d;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (wr_en) begin
            buf_q[wr_addr] <= bus.in_flit;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = (state_q == S_SEND);
    assign bus.out_flit  = (state_q == S_SEND) ? buf_q[rd_q] : '0;
    assign bus.out_last  = (state_q == S_SEND) && (rd_q == tail_q);

    assign busy        = (state_q != S_IDLE);
    assign tx_done     = (state_q == S_DONE);
    assign tx_fail     = (state_q == S_FAIL);
    assign dbg_state_o = state_q;
endmodule

// File: tb/tb_packet_flit_transmitter.sv
// Directed bench for packet_flit_transmitter: load, serialise, stall, ack,
// expiry (with or without PACKET_TX_RETRY_EN) and mid-packet reset.
module tb_packet_flit_transmitter;
    localparam int FW = 64;
    localparam int IW = 8;
    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_SEND = 3'd2;
    localparam logic [2:0] ST_WAIT = 3'd3;
    localparam logic [2:0] ST_DONE = 3'd4;
    localparam logic [2:0] ST_FAIL = 3'd5;

    // clock / reset
    logic clk;
    logic rst;
    logic busy, tx_done, tx_fail;
    logic [2:0] dbg_state;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    packet_flit_transmitter_if #(.FLIT_WIDTH(FW), .PACKET_ID_WIDTH(IW)) dif ();

    packet_flit_transmitter #(
        .MAX_NUM_OF_FLIT(8),
        .EXPIRE_TIME(100),
        .FLIT_WIDTH(FW),
        .PACKET_ID_WIDTH(IW),
        .MAX_RETRY(3)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(dif),
        .busy(busy),
        .tx_done(tx_done),
        .tx_fail(tx_fail),
        .dbg_state_o(dbg_state)
    );

    // scoreboard
    logic [FW-1:0] exp_q[$];
    int tests = 0;
    int fails = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // driver tasks
    task automatic push_exp(input int n, input logic [FW-1:0] base);
        for (int i = 0; i < n; i++) exp_q.push_back(base + FW'(i));
    endtask

    task automatic send_packet(input int n, input logic [IW-1:0] id,
                               input logic [FW-1:0] base, input bit mark_last);
        int g;
        for (int i = 0; i < n; i++) begin
            dif.in_valid     = 1'b1;
            dif.in_flit      = base + FW'(i);
            dif.in_last      = mark_last && (i == n - 1);
            // later flits carry a different id; only the first one is captured
            dif.in_packet_id = (i == 0) ? id : ~id;
            g = 0;
            while (!dif.in_ready && g < 20) begin
                tick();
                g++;
            end
            check("load_in_ready", dif.in_ready, 1);
            exp_q.push_back(base + FW'(i));
            tick();
        end
        dif.in_valid = 1'b0;
        dif.in_last  = 1'b0;
    endtask

    task automatic recv_packet(input int n, input string tag);
        int got = 0;
        int guard = 0;
        logic [FW-1:0] e;
        while (got < n && guard < 200) begin
            if (dif.out_valid && dif.out_ready) begin
                e = exp_q.pop_front();
                check({tag, "_flit"}, dif.out_flit, e);
                check({tag, "_last"}, dif.out_last, (got == n - 1));
                got++;
            end
            tick();
            guard++;
        end
        check({tag, "_count"}, got, n);
    endtask

    task automatic send_ack(input logic [IW-1:0] id);
        dif.ack_valid     = 1'b1;
        dif.ack_packet_id = id;
        tick();
        dif.ack_valid     = 1'b0;
        dif.ack_packet_id = '0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst               = 1'b1;
        dif.in_valid      = 1'b0;
        dif.in_flit       = '0;
        dif.in_last       = 1'b0;
        dif.in_packet_id  = '0;
        dif.out_ready     = 1'b1;
        dif.ack_valid     = 1'b0;
        dif.ack_packet_id = '0;

        // reset values
        #2;
        check("rst_in_ready", dif.in_ready, 0);
        check("rst_out_valid", dif.out_valid, 0);
        check("rst_out_last", dif.out_last, 0);
        check("rst_out_flit", dif.out_flit, 0);
        check("rst_busy", busy, 0);
        check("rst_tx_done", tx_done, 0);
        check("rst_tx_fail", tx_fail, 0);
        check("rst_state", dbg_state, ST_IDLE);
        tick();
        tick();
        rst = 1'b0;
        tick();
        check("idle_in_ready", dif.in_ready, 1);

        // 3-flit packet, ack ten cycles after the last flit
        send_packet(3, 8'h05, 64'hA0, 1'b1);
        check("p3_state_send", dbg_state, ST_SEND);
        check("p3_busy", busy, 1);
        check("p3_in_ready", dif.in_ready, 0);
        recv_packet(3, "p3");
        check("p3_wait", dbg_state, ST_WAIT);
        check("p3_out_valid_drop", dif.out_valid, 0);
        repeat (9) tick();
        send_ack(8'h05);
        check("p3_tx_done", tx_done, 1);
        check("p3_state_done", dbg_state, ST_DONE);
        tick();
        check("p3_tx_done_once", tx_done, 0);
        check("p3_busy_after", busy, 0);
        check("p3_ready_after_done", dif.in_ready, 1);

        // single flit in IDLE goes straight to SEND
        send_packet(1, 8'h11, 64'hBEEF, 1'b1);
        check("p1_state_send", dbg_state, ST_SEND);
        recv_packet(1, "p1");
        send_ack(8'h11);
        check("p1_tx_done", tx_done, 1);
        tick();

        // eight flits without in_last: the eighth is forced last
        send_packet(8, 8'h22, 64'h1000, 1'b0);
        check("p8_in_ready_low", dif.in_ready, 0);
        check("p8_state_send", dbg_state, ST_SEND);
        recv_packet(8, "p8");
        send_ack(8'h22);
        check("p8_tx_done", tx_done, 1);
        tick();

        // stall pattern 1,0,0,1 on out_ready
        dif.out_ready = 1'b0;
        send_packet(3, 8'h33, 64'h2000, 1'b1);
        exp_q.delete();
        dif.out_ready = 1'b1;
        check("stall_f0", dif.out_flit, 64'h2000);
        tick();
        dif.out_ready = 1'b0;
        check("stall_f1_a", dif.out_flit, 64'h2001);
        tick();
        check("stall_f1_b", dif.out_flit, 64'h2001);
        check("stall_valid_held", dif.out_valid, 1);
        tick();
        dif.out_ready = 1'b1;
        check("stall_f1_c", dif.out_flit, 64'h2001);
        check("stall_f1_not_last", dif.out_last, 0);
        tick();
        check("stall_f2", dif.out_flit, 64'h2002);
        check("stall_f2_last", dif.out_last, 1);
        tick();
        check("stall_wait", dbg_state, ST_WAIT);
        send_ack(8'h33);
        check("stall_tx_done", tx_done, 1);
        tick();

        // mismatched ack then expiry
        send_packet(2, 8'h05, 64'hC0, 1'b1);
        recv_packet(2, "exp");
        tick();
        tick();
        send_ack(8'h06);
        check("exp_mismatch_ignored", dbg_state, ST_WAIT);
        repeat (96) tick();
        check("exp_before_timeout", dbg_state, ST_WAIT);
        check("exp_no_early_fail", tx_fail, 0);
        tick();
`ifdef PACKET_TX_RETRY_EN
        for (int r = 0; r < 3; r++) begin
            check("retry_send", dbg_state, ST_SEND);
            push_exp(2, 64'hC0);
            recv_packet(2, "retry");
            repeat (99) tick();
            check("retry_wait", dbg_state, ST_WAIT);
            tick();
        end
`endif
        check("exp_tx_fail", tx_fail, 1);
        check("exp_state_fail", dbg_state, ST_FAIL);
        check("exp_no_done", tx_done, 0);
        tick();
        check("exp_tx_fail_once", tx_fail, 0);
        check("exp_idle", dbg_state, ST_IDLE);

        // matching ack on the timeout cycle wins
        send_packet(1, 8'h44, 64'hD0, 1'b1);
        recv_packet(1, "race");
        repeat (99) tick();
        send_ack(8'h44);
        check("race_tx_done", tx_done, 1);
        check("race_tx_fail", tx_fail, 0);
        tick();

        // reset in the middle of SEND
        dif.out_ready = 1'b0;
        send_packet(3, 8'h55, 64'hE0, 1'b1);
        exp_q.delete();
        check("mid_rst_pre_valid", dif.out_valid, 1);
        rst = 1'b1;
        #1;
        check("mid_rst_out_valid", dif.out_valid, 0);
        check("mid_rst_state", dbg_state, ST_IDLE);
        check("mid_rst_busy", busy, 0);
        tick();
        rst = 1'b0;
        check("mid_rst_no_done", tx_done, 0);
        check("mid_rst_no_fail", tx_fail, 0);
        tick();
        check("mid_rst_ready", dif.in_ready, 1);
        dif.out_ready = 1'b1;

        // traffic resumes after reset
        send_packet(1, 8'h66, 64'hF0, 1'b1);
        recv_packet(1, "post");
        send_ack(8'h66);
        check("post_tx_done", tx_done, 1);
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/packet_flit_transmitter.md
Name: packet_flit_transmitter

Overview:
- Transmit-side counterpart of the flit reassembly buffer: the reassembler collects flits into packets; this block sends them out.
- Captures one outbound packet of up to MAX_NUM_OF_FLIT flits from the local node logic.
- Serialises the packet onto the link as a flit stream with valid/ready handshake.
- Holds the packet until a matching packet-id acknowledgement arrives or an expiry timer fires.

Parameters:
- MAX_NUM_OF_FLIT, 8, flit capacity of the packet buffer
- EXPIRE_TIME, 100, cycles to wait for an ack after the last flit is sent
- FLIT_WIDTH, 64, bits per flit
- PACKET_ID_WIDTH, 8, bits of packet identifier
- MAX_RETRY, 3, retransmissions before failure (used only with PACKET_TX_RETRY_EN)

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  load-side flit valid
- in_ready  out  1  load-side ready
- in_flit  in  FLIT_WIDTH  flit to load
- in_last  in  1  marks final flit of packet
- in_packet_id  in  PACKET_ID_WIDTH  packet id, sampled with first flit only
- out_valid  out  1  link-side flit valid
- out_ready  in  1  link-side ready
- out_flit  out  FLIT_WIDTH  flit on link
- out_last  out  1  high with final flit
- ack_valid  in  1  acknowledgement strobe
- ack_packet_id  in  PACKET_ID_WIDTH  id being acknowledged
- busy  out  1  high in any state other than IDLE
- tx_done  out  1  one-cycle pulse, packet acknowledged
- tx_fail  out  1  one-cycle pulse, packet abandoned

Behaviour:
- Reset:
  - state=IDLE; all counters 0; packet id register 0.
  - in_ready=0, out_valid=0, out_last=0, out_flit=0, busy=0, tx_done=0, tx_fail=0.
  - Asserting rst mid-packet discards the packet; no done or fail pulse is produced.
- Registers: buffer[MAX_NUM_OF_FLIT], tail_index ($clog2(MAX_NUM_OF_FLIT) bits), rd_index, timer ($clog2(EXPIRE_TIME) bits), retry count, packet id.
- States: IDLE, LOAD, SEND, WAIT_ACK, DONE, FAIL.
- IDLE:
  - in_ready=1.
  - On in_valid: store flit in buffer[0], capture in_packet_id, set tail_index=0.
  - If in_last: go to SEND. Otherwise go to LOAD.
- LOAD:
  - in_ready=1; each accepted flit is written to buffer[tail_index+1] and tail_index increments.
  - Go to SEND on an accepted flit with in_last=1.
  - Go to SEND when the MAX_NUM_OF_FLIT-th flit is accepted, whether or not in_last is set (forced last; no overflow, no wrap).
  - in_ready=0 in all other states.
- SEND:
  - rd_index starts at 0; out_valid=1; out_flit=buffer[rd_index]; out_last=(rd_index==tail_index).
  - Output is registered: the first flit is visible the cycle after the SEND transition.
  - Flit is held stable until out_valid&&out_ready, then rd_index increments.
  - A transfer with out_last=1 moves to WAIT_ACK with timer=0 and out_valid dropping the next cycle.
  - A stalled out_ready holds the state indefinitely; the timer does not run in SEND.
  - Acks are ignored in SEND.
- WAIT_ACK:
  - timer increments each cycle.
  - ack_valid with ack_packet_id equal to the stored id moves to DONE. A mismatched id is ignored.
  - Timer reaching EXPIRE_TIME-1 with no matching ack this cycle is a timeout; timeout goes to FAIL.
  - Matching ack and timeout in the same cycle: the ack wins.
- DONE: tx_done=1 for exactly one cycle, then IDLE.
- FAIL: tx_fail=1 for exactly one cycle, then IDLE.
- A packet can be accepted in IDLE on the cycle immediately after DONE or FAIL.
- busy=(state!=IDLE).

Optional Feature:
- Macro: PACKET_TX_RETRY_EN.
- Defined:
  - A WAIT_ACK timeout with retry count < MAX_RETRY increments the retry count, resets rd_index, and returns to SEND. The buffer is retransmitted unchanged.
  - A timeout with retry count == MAX_RETRY goes to FAIL.
  - The retry count clears in IDLE.
- Undefined: the first timeout goes to FAIL; no retry register is present.

Test Plan:
- 3-flit packet, id 0x05, out_ready=1, ack id 0x05 ten cycles after the last flit -> flits appear in load order, out_last only on the 3rd, tx_done pulses once, busy=0 afterwards.
- Single flit with in_last=1 in IDLE -> goes straight to SEND; one flit out with out_last=1.
- 8 flits loaded, none with in_last -> the 8th is forced last; exactly 8 flits out, the 8th with out_last=1, in_ready=0 after loading.
- out_ready toggled 1,0,0,1 during SEND -> each flit is held stable while stalled; no flit is dropped or duplicated.
- Ack id 0x06 for packet 0x05, then no ack -> mismatch is ignored; without the macro, tx_fail pulses 100 cycles after WAIT_ACK entry; with the macro, 3 retransmissions then tx_fail.
- Matching ack in the same cycle as timeout -> tx_done=1, tx_fail=0; rst asserted mid-SEND -> out_valid=0 immediately and state=IDLE.
